z80_int_ctrl: RTL and testbench

- Vectored, prioritised interrupt controller for the cpu_z80 core.
- Latches up to N_SRC peripheral requests and drives the CPU INT line.
- On the Z80 interrupt-acknowledge cycle (M1 and IORQ both high), supplies an 8-bit vector for the CPU's DI bus mux.
- Tracks in-service levels for nesting; software controls it through a 4-register I/O window.

---
 rtl/z80_int_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_z80_int_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/z80_int_ctrl.sv
// Vectored, prioritised interrupt controller for the Z80 core: edge-latched requests, nesting via ISR, 4-register I/O window.
// Optional RETI (ED 4D) opcode snooping is compiled in with `define Z80_INT_CTRL_RETI_DETECT_EN.
module z80_int_ctrl #(
  parameter int          N_SRC    = 8,
  parameter logic [7:0]  IO_BASE  = 8'h40,
  parameter logic [7:0]  VEC_BASE = 8'h80
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic [N_SRC-1:0] IRQ,
  input  logic [15:0]      ADDR,
  input  logic [7:0]       DO,
  input  logic [7:0]       DI,
  input  logic             WR,
  input  logic             IORQ,
  input  logic             MREQ,
  input  logic             M1,
  output logic             INT,
  output logic [7:0]       DATA_OUT,
  output logic             DATA_OE
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_ACK} state_t;

  localparam logic [3:0] SPUR_ID = 4'(N_SRC);

  state_t             r_state, w_state_nxt;
  logic [N_SRC-1:0]   r_irq_q, r_pend, r_mask, r_isr;
  logic [N_SRC-1:0]   w_pend_nxt, w_isr_nxt, w_isr_low, w_id_onehot;
  logic [3:0]         r_id, w_cand_id;
  logic               r_int, r_wr_q;
  logic               w_cand_vld, w_blk, w_low_found;
  logic               w_sel, w_ack, w_wr_fire, w_freeze, w_ack_done;
  logic               w_mask_we, w_pend_w1c, w_eoi_wr, w_eoi, w_reti;
  logic [7:0]         w_rd_dat, w_vec;

  assign w_sel      = IORQ & ~M1 & (ADDR[7:2] == IO_BASE[7:2]);
  assign w_ack      = M1 & IORQ;
  assign w_wr_fire  = w_sel & WR & ~r_wr_q;
  assign w_mask_we  = w_wr_fire & (ADDR[1:0] == 2'd0);
  assign w_pend_w1c = w_wr_fire & (ADDR[1:0] == 2'd1);
  assign w_eoi_wr   = w_wr_fire & (ADDR[1:0] == 2'd2);
  assign w_eoi      = w_eoi_wr | w_reti;

  // Candidate must sit strictly above (lower index than) the highest-priority level in service.
  always_comb begin
    w_cand_vld  = 1'b0;
    w_cand_id   = 4'd0;
    w_blk       = 1'b0;
    w_isr_low   = '0;
    w_low_found = 1'b0;
    w_id_onehot = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (r_isr[i]) w_blk = 1'b1;
      if (!w_blk && !w_cand_vld && r_pend[i] && !r_mask[i]) begin
        w_cand_vld = 1'b1;
        w_cand_id  = 4'(i);
      end
      if (r_isr[i] && !w_low_found) begin
        w_low_found  = 1'b1;
        w_isr_low[i] = 1'b1;
      end
      w_id_onehot[i] = (r_id == 4'(i));
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_freeze    = 1'b0;
    w_ack_done  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_ack) begin
          w_state_nxt = S_ACK;
          w_freeze    = 1'b1;
        end else if (w_cand_vld) begin
          w_state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        if (w_ack) begin
          w_state_nxt = S_ACK;
          w_freeze    = 1'b1;
        end else if (!w_cand_vld) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_ACK: begin
        if (!w_ack) begin
          w_state_nxt = S_IDLE;
          w_ack_done  = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // A new edge wins over a same-cycle clear; the ack's ISR set lands after the EOI clear.
  always_comb begin
    w_pend_nxt = r_pend;
    if (w_pend_w1c) w_pend_nxt = w_pend_nxt & ~DO[N_SRC-1:0];
    if (w_ack_done) w_pend_nxt = w_pend_nxt & ~w_id_onehot;
    w_pend_nxt = w_pend_nxt | (IRQ & ~r_irq_q);

    w_isr_nxt = r_isr;
    if (w_eoi)      w_isr_nxt = w_isr_nxt & ~w_isr_low;
    if (w_ack_done) w_isr_nxt = w_isr_nxt | w_id_onehot;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state <= S_IDLE;
      r_irq_q <= '0;
      r_pend  <= '0;
      r_mask  <= '1;
      r_isr   <= '0;
      r_id    <= 4'd0;
      r_int   <= 1'b0;
      r_wr_q  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_irq_q <= IRQ;
      r_pend  <= w_pend_nxt;
      r_isr   <= w_isr_nxt;
      r_int   <= (w_state_nxt == S_REQ);
      r_wr_q  <= w_sel & WR;
      if (w_mask_we) r_mask <= DO[N_SRC-1:0];
      if (w_freeze)  r_id   <= w_cand_vld ? w_cand_id : SPUR_ID;
    end
  end

  always_comb begin
    w_rd_dat = 8'h00;
    case (ADDR[1:0])
      2'd0:    w_rd_dat[N_SRC-1:0] = r_mask;
      2'd1:    w_rd_dat[N_SRC-1:0] = r_pend;
      2'd3:    w_rd_dat[N_SRC-1:0] = r_isr;
      default: w_rd_dat = 8'h00;
    endcase
  end

  assign w_vec = VEC_BASE + {3'b000, r_id, 1'b0};

  always_comb begin
    DATA_OE  = 1'b0;
    DATA_OUT = 8'h00;
    if (RESET_N) begin
      if ((r_state == S_ACK) && w_ack) begin
        DATA_OE  = 1'b1;
        DATA_OUT = w_vec;
      end else if (w_sel && !WR) begin
        DATA_OE  = 1'b1;
        DATA_OUT = w_rd_dat;
      end
    end
  end

  assign INT = r_int;

`ifdef Z80_INT_CTRL_RETI_DETECT_EN
  logic       r_m1_q, r_fetch_vld, r_ed_seen;
  logic [7:0] r_fetch_byte;
  logic       w_m1_fall;
  logic       w_unused_bits;

  assign w_m1_fall     = r_m1_q & ~M1;
  assign w_reti        = w_m1_fall & r_fetch_vld & r_ed_seen & (r_fetch_byte == 8'h4D);
  assign w_unused_bits = ^ADDR[15:8];

  // Opcode byte is captured while M1&MREQ is up and judged when M1 falls.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_m1_q       <= 1'b0;
      r_fetch_vld  <= 1'b0;
      r_ed_seen    <= 1'b0;
      r_fetch_byte <= 8'h00;
    end else begin
      r_m1_q <= M1;
      if (M1 && MREQ) begin
        r_fetch_vld  <= 1'b1;
        r_fetch_byte <= DI;
      end else if (w_m1_fall) begin
        r_fetch_vld <= 1'b0;
      end
      if (w_m1_fall && r_fetch_vld) r_ed_seen <= ~r_ed_seen & (r_fetch_byte == 8'hED);
    end
  end
`else
  logic w_unused_bits;
  assign w_reti        = 1'b0;
  assign w_unused_bits = ^{ADDR[15:8], DI, MREQ};
`endif

endmodule

// File: tb/tb_z80_int_ctrl.sv
// Directed, table-driven bench for z80_int_ctrl plus hand sequences for multi-cycle corner cases.
module tb_z80_int_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  irq;
  logic [15:0] addr;
  logic [7:0]  cpu_do, cpu_di;
  logic        wr, iorq, mreq, m1;
  logic        int_o, data_oe;
  logic [7:0]  data_out;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  z80_int_ctrl dut (
    .CLK(clk), .RESET_N(rst_n), .IRQ(irq), .ADDR(addr), .DO(cpu_do), .DI(cpu_di),
    .WR(wr), .IORQ(iorq), .MREQ(mreq), .M1(m1),
    .INT(int_o), .DATA_OUT(data_out), .DATA_OE(data_oe)
  );

  typedef enum {OP_WR, OP_RD, OP_NRD, OP_IRQ, OP_ACK, OP_INT} op_e;
  typedef struct {
    op_e         op;
    logic [15:0] port;
    logic [7:0]  dat;
    logic [7:0]  exp;
  } vec_t;

  localparam int NV = 40;
  vec_t tbl [0:NV-1];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %04h expected %04h", nm, act, exp);
    end
  endtask

  task automatic io_wr(input logic [15:0] p, input logic [7:0] d);
    addr = p; cpu_do = d; wr = 1'b1; iorq = 1'b1;
    tick();
    tick();
    iorq = 1'b0; wr = 1'b0;
    tick();
  endtask

  task automatic io_rd(input logic [15:0] p, output logic [7:0] d, output logic oe);
    addr = p; wr = 1'b0; iorq = 1'b1;
    @(negedge clk);
    d = data_out; oe = data_oe;
    iorq = 1'b0;
    tick();
  endtask

  task automatic pulse_irq(input logic [7:0] b);
    irq = b;
    tick();
    irq = 8'h00;
    tick();
  endtask

  task automatic do_ack(output logic [7:0] v, output logic oe);
    m1 = 1'b1; iorq = 1'b1;
    tick();
    @(negedge clk);
    v = data_out; oe = data_oe;
    m1 = 1'b0; iorq = 1'b0;
    tick();
    tick();
  endtask

  task automatic fetch(input logic [7:0] b);
    m1 = 1'b1; mreq = 1'b1; cpu_di = b;
    tick();
    m1 = 1'b0; mreq = 1'b0;
    tick();
  endtask

  logic [7:0] d;
  logic       oe;

  initial begin
    tbl[0]  = '{OP_RD,  16'h0040, 8'h00, 8'hFF};
    tbl[1]  = '{OP_RD,  16'h0041, 8'h00, 8'h00};
    tbl[2]  = '{OP_RD,  16'h0043, 8'h00, 8'h00};
    tbl[3]  = '{OP_INT, 16'h0000, 8'h00, 8'h00};
    tbl[4]  = '{OP_WR,  16'h0040, 8'h00, 8'h00};
    tbl[5]  = '{OP_IRQ, 16'h0000, 8'h08, 8'h01};
    tbl[6]  = '{OP_ACK, 16'h0000, 8'h00, 8'h86};
    tbl[7]  = '{OP_INT, 16'h0000, 8'h00, 8'h00};
    tbl[8]  = '{OP_RD,  16'h0043, 8'h00, 8'h08};
    tbl[9]  = '{OP_RD,  16'h0041, 8'h00, 8'h00};
    tbl[10] = '{OP_IRQ, 16'h0000, 8'h40, 8'h00};
    tbl[11] = '{OP_IRQ, 16'h0000, 8'h01, 8'h01};
    tbl[12] = '{OP_ACK, 16'h0000, 8'h00, 8'h80};
    tbl[13] = '{OP_RD,  16'h0043, 8'h00, 8'h09};
    tbl[14] = '{OP_INT, 16'h0000, 8'h00, 8'h00};
    tbl[15] = '{OP_WR,  16'h0042, 8'h5A, 8'h00};
    tbl[16] = '{OP_RD,  16'h0043, 8'h00, 8'h08};
    tbl[17] = '{OP_INT, 16'h0000, 8'h00, 8'h00};
    tbl[18] = '{OP_WR,  16'h0042, 8'h00, 8'h00};
    tbl[19] = '{OP_INT, 16'h0000, 8'h00, 8'h01};
    tbl[20] = '{OP_ACK, 16'h0000, 8'h00, 8'h8C};
    tbl[21] = '{OP_WR,  16'h0042, 8'h00, 8'h00};
    tbl[22] = '{OP_RD,  16'h0043, 8'h00, 8'h00};
    tbl[23] = '{OP_IRQ, 16'h0000, 8'h22, 8'h01};
    tbl[24] = '{OP_ACK, 16'h0000, 8'h00, 8'h82};
    tbl[25] = '{OP_INT, 16'h0000, 8'h00, 8'h00};
    tbl[26] = '{OP_RD,  16'h0041, 8'h00, 8'h20};
    tbl[27] = '{OP_WR,  16'h0042, 8'h00, 8'h00};
    tbl[28] = '{OP_INT, 16'h0000, 8'h00, 8'h01};
    tbl[29] = '{OP_ACK, 16'h0000, 8'h00, 8'h8A};
    tbl[30] = '{OP_WR,  16'h0042, 8'h00, 8'h00};
    tbl[31] = '{OP_RD,  16'h0043, 8'h00, 8'h00};
    tbl[32] = '{OP_WR,  16'h0040, 8'hFF, 8'h00};
    tbl[33] = '{OP_IRQ, 16'h0000, 8'h04, 8'h00};
    tbl[34] = '{OP_RD,  16'h0041, 8'h00, 8'h04};
    tbl[35] = '{OP_WR,  16'h0041, 8'h04, 8'h00};
    tbl[36] = '{OP_RD,  16'h0041, 8'h00, 8'h00};
    tbl[37] = '{OP_RD,  16'h0042, 8'h00, 8'h00};
    tbl[38] = '{OP_NRD, 16'h0044, 8'h00, 8'h00};
    tbl[39] = '{OP_RD,  16'h1240, 8'h00, 8'hFF};

    rst_n = 1'b0; irq = 8'h00; addr = 16'h0000; cpu_do = 8'h00; cpu_di = 8'h00;
    wr = 1'b0; iorq = 1'b0; mreq = 1'b0; m1 = 1'b0;
    #1;
    check("reset_int", {15'd0, int_o}, 16'h0000);
    check("reset_oe", {7'd0, data_oe, data_out}, 16'h0000);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    for (int k = 0; k < NV; k++) begin
      case (tbl[k].op)
        OP_WR:  io_wr(tbl[k].port, tbl[k].dat);
        OP_RD: begin
          io_rd(tbl[k].port, d, oe);
          check($sformatf("v%0d rd %04h", k, tbl[k].port), {7'd0, oe, d}, {8'h01, tbl[k].exp});
        end
        OP_NRD: begin
          io_rd(tbl[k].port, d, oe);
          check($sformatf("v%0d nrd %04h", k, tbl[k].port), {15'd0, oe}, 16'h0000);
        end
        OP_IRQ: begin
          pulse_irq(tbl[k].dat);
          check($sformatf("v%0d irq %02h int", k, tbl[k].dat), {15'd0, int_o}, {8'h00, tbl[k].exp});
        end
        OP_ACK: begin
          do_ack(d, oe);
          check($sformatf("v%0d ack vec", k), {7'd0, oe, d}, {8'h01, tbl[k].exp});
        end
        default: check($sformatf("v%0d int", k), {15'd0, int_o}, {8'h00, tbl[k].exp});
      endcase
    end

    // Latency, then mask-before-ack and a forced spurious ack.
    io_wr(16'h0040, 8'h00);
    irq = 8'h04;
    tick();
    check("lat_edge_k", {15'd0, int_o}, 16'h0000);
    irq = 8'h00;
    tick();
    check("lat_edge_k1", {15'd0, int_o}, 16'h0001);
    addr = 16'h0040; cpu_do = 8'hFF; iorq = 1'b1; wr = 1'b1;
    tick();
    tick();
    check("mask_drops_int", {15'd0, int_o}, 16'h0000);
    iorq = 1'b0; wr = 1'b0;
    tick();
    do_ack(d, oe);
    check("spurious_vec", {7'd0, oe, d}, 16'h0190);
    io_rd(16'h0043, d, oe);
    check("spurious_isr", {8'h00, d}, 16'h0000);
    io_rd(16'h0041, d, oe);
    check("spurious_pend", {8'h00, d}, 16'h0004);

    // Same-cycle W1C and new edge on bit 2.
    io_wr(16'h0041, 8'h04);
    addr = 16'h0041; cpu_do = 8'h04; iorq = 1'b1; wr = 1'b1; irq = 8'h04;
    tick();
    iorq = 1'b0; wr = 1'b0; irq = 8'h00;
    tick();
    io_rd(16'h0041, d, oe);
    check("set_beats_w1c", {8'h00, d}, 16'h0004);

    // Ack completion coincides with an EOI write.
    io_wr(16'h0041, 8'hFF);
    io_wr(16'h0040, 8'h00);
    pulse_irq(8'h08);
    do_ack(d, oe);
    check("nest_outer_vec", {7'd0, oe, d}, 16'h0186);
    pulse_irq(8'h01);
    check("nest_inner_int", {15'd0, int_o}, 16'h0001);
    m1 = 1'b1; iorq = 1'b1;
    tick();
    @(negedge clk);
    check("nest_inner_vec", {7'd0, data_oe, data_out}, 16'h0180);
    m1 = 1'b0; wr = 1'b1; addr = 16'h0042;
    tick();
    wr = 1'b0; iorq = 1'b0;
    tick();
    io_rd(16'h0043, d, oe);
    check("eoi_then_ack_isr", {8'h00, d}, 16'h0001);
    io_wr(16'h0042, 8'h00);

    // Reset asserted in the middle of an ack.
    pulse_irq(8'h10);
    m1 = 1'b1; iorq = 1'b1;
    tick();
    @(negedge clk);
    check("pre_rst_vec", {7'd0, data_oe, data_out}, 16'h0188);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_ack", {14'd0, data_oe, int_o}, 16'h0000);
    m1 = 1'b0; iorq = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    io_rd(16'h0043, d, oe);
    check("rst_isr", {8'h00, d}, 16'h0000);
    io_rd(16'h0041, d, oe);
    check("rst_pend", {8'h00, d}, 16'h0000);

`ifdef Z80_INT_CTRL_RETI_DETECT_EN
    io_wr(16'h0040, 8'h00);
    pulse_irq(8'h10);
    do_ack(d, oe);
    check("reti_vec", {7'd0, oe, d}, 16'h0188);
    fetch(8'hED);
    fetch(8'h4D);
    io_rd(16'h0043, d, oe);
    check("reti_clears", {8'h00, d}, 16'h0000);
    pulse_irq(8'h10);
    do_ack(d, oe);
    fetch(8'hED);
    fetch(8'h45);
    io_rd(16'h0043, d, oe);
    check("retn_keeps", {8'h00, d}, 16'h0010);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
